// File: rtl/aes_pkg.sv
// Shared AES definitions: round/key counts, FSM encoding, S-box table and GF(2^8) helpers.
// The S-box lookup is shared with the key-schedule block.
package aes_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = AES_NR + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_state_e;

  // Byte 0x00 sits in the top 8 bits, 0xff in the bottom 8.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // MSB index of entry x is 2047-8x = {~x, 3'b111}.
  function automatic logic [7:0] sbox_f(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One state column, row 0 in the top byte.
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box, one byte lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = sbox_f(a);
endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock over a valid/ready handshake.
// AES_ENC_DBG_EN adds busy_o/round_o trace outputs.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int NK = AES_NK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      pt_i,
  input  logic [128*NK-1:0] rk_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ct_o
`ifdef AES_ENC_DBG_EN
  ,
  output logic              busy_o,
  output logic [3:0]        round_o
`endif
);

  localparam int NB = 16;

  aes_state_e   state, state_nx;
  logic [3:0]   round;
  logic [127:0] st, sb, sr, mc, rk_sel, rnd_out;
  logic         accept, last;

  assign in_ready  = rst_n & (state == IDLE);
  assign accept    = in_valid & in_ready;
  assign last      = (round == 4'(NR));
  assign out_valid = (state == DONE);
  assign ct_o      = out_valid ? st : '0;

  // SubBytes lanes, byte b at st[127-8b -: 8]
  for (genvar b = 0; b < NB; b++) begin : g_sub
    aes_sbox u_sbox (.a(st[127-8*b -: 8]), .y(sb[127-8*b -: 8]));
  end

  // ShiftRows: row r rotates left by r columns
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign sr[127-8*(r+4*c) -: 8] = sb[127-8*(r+4*((c+r)%4)) -: 8];
    end
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
  end

  always_comb begin
    rk_sel = '0;
    for (int r = 0; r < NK; r++)
      if (round == 4'(r)) rk_sel = rk_i[128*NK-1-128*r -: 128];
  end

  assign rnd_out = (last ? sr : mc) ^ rk_sel;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)    state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Round counter saturates at NR and is cleared on the way back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= '0;
      round <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            st    <= pt_i ^ rk_i[128*NK-1 -: 128];
            round <= 4'd1;
          end else begin
            round <= '0;
          end
        end
        RUN: begin
          st <= rnd_out;
          if (!last) round <= round + 4'd1;
        end
        DONE:    if (out_ready) round <= '0;
        default: round <= '0;
      endcase
    end
  end

`ifdef AES_ENC_DBG_EN
  assign busy_o  = (state != IDLE);
  assign round_o = round;
`endif

endmodule
